// File: rtl/pm_noc_fifo_pkg.sv
// Shared definitions for the PM-domain NoC async FIFO: default sizing,
// pointer gray/binary conversion and the outbound arbiter state encoding.
package pm_noc_fifo_pkg;

  localparam int unsigned NOC_ASYNC_FIFO_PACKET_SIZE = 32;
  localparam int unsigned NOC_ASYNC_FIFO_AWIDTH      = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Conversions operate on a 32-bit container; callers size-cast to AWIDTH+1.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/pm_gray_ptr_sync.sv
// Brings a gray-coded pointer from a foreign clock domain through a flop
// chain and converts the synchronised value back to binary.
module pm_gray_ptr_sync
  import pm_noc_fifo_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] rptr_s_o
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];

  // Synchroniser chain; only gray values cross, so one-bit changes are safe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gray_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign rptr_s_o = WIDTH'(gray2bin(32'(r_sync[SYNC_STAGES-1])));

endmodule

// File: rtl/pm_noc_out_arbiter.sv
// Outbound PM-domain NoC FIFO write side: round-robin arbitration between
// packet sources, locked for the duration of a multi-flit packet, plus the
// FIFO storage, write pointer and gray pointer exchange with the NoC domain.
module pm_noc_out_arbiter
  import pm_noc_fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned PACKET_SIZE = NOC_ASYNC_FIFO_PACKET_SIZE,
  parameter int unsigned AWIDTH      = NOC_ASYNC_FIFO_AWIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                           clk_pm_i,
  input  logic                           reset_pm_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ-1:0]             req_last_i,
  input  logic [NUM_REQ*PACKET_SIZE-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [PACKET_SIZE-1:0]         noc_fifo_pm_out_data_o,
  input  logic [AWIDTH:0]                noc_fifo_pm_out_raddr_i,
  output logic [AWIDTH:0]                noc_fifo_pm_out_waddr_o,
  output logic [NUM_REQ-1:0]             owner_o,
  output logic                           full_o
);

  localparam int unsigned IW    = $clog2(NUM_REQ);
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [PACKET_SIZE-1:0] r_mem [DEPTH];
  logic [AWIDTH:0]        r_wptr;
  logic [AWIDTH:0]        r_waddr;
  arb_state_t             r_state;
  logic [NUM_REQ-1:0]     r_owner;
  logic [IW-1:0]          r_owner_idx;
  logic [IW-1:0]          r_rr_ptr;

  logic [AWIDTH:0]        w_rptr_s;
  logic [AWIDTH:0]        w_wptr_nxt;
  logic [AWIDTH-1:0]      w_rd_idx;
  logic                   w_full;
  logic                   w_cand_found;
  logic [IW-1:0]          w_cand_idx;
  logic [IW-1:0]          w_sel;
  logic [NUM_REQ-1:0]     w_ready;
  logic                   w_accept;
  logic                   w_last;
  logic [PACKET_SIZE-1:0] w_data;
  logic [IW-1:0]          w_rr_next;

  pm_gray_ptr_sync #(
    .WIDTH       (AWIDTH + 1),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i    (clk_pm_i),
    .reset_i  (reset_pm_i),
    .gray_i   (noc_fifo_pm_out_raddr_i),
    .rptr_s_o (w_rptr_s)
  );

  assign w_full = (r_wptr[AWIDTH] != w_rptr_s[AWIDTH]) &&
                  (r_wptr[AWIDTH-1:0] == w_rptr_s[AWIDTH-1:0]);

  // Round-robin candidate: first valid requester at or after r_rr_ptr.
  always_comb begin
    logic [IW-1:0] v_idx;
    v_idx        = '0;
    w_cand_found = 1'b0;
    w_cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      v_idx = IW'((32'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_cand_found && req_valid_i[v_idx]) begin
        w_cand_found = 1'b1;
        w_cand_idx   = v_idx;
      end
    end
  end

  // Only the eligible requester sees ready; the lock makes it the owner.
  always_comb begin
    w_ready = '0;
    w_sel   = w_cand_idx;
    if (r_state == LOCKED) begin
      w_sel                = r_owner_idx;
      w_ready[r_owner_idx] = !w_full;
    end else if (w_cand_found) begin
      w_ready[w_cand_idx] = !w_full;
    end
    if (reset_pm_i) begin
      w_ready = '0;
    end
  end

  assign w_accept   = req_valid_i[w_sel] & w_ready[w_sel];
  assign w_last     = req_last_i[w_sel];
  assign w_data     = req_data_i[32'(w_sel)*PACKET_SIZE +: PACKET_SIZE];
  assign w_rr_next  = (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_wptr_nxt = r_wptr + 1'b1;
  assign w_rd_idx   = AWIDTH'(gray2bin(32'(noc_fifo_pm_out_raddr_i)));

  // Arbiter FSM together with the write pointer it advances on each accept.
  always_ff @(posedge clk_pm_i) begin
    if (reset_pm_i) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_owner_idx <= '0;
      r_rr_ptr    <= '0;
      r_wptr      <= '0;
      r_waddr     <= '0;
    end else if (w_accept) begin
      r_wptr  <= w_wptr_nxt;
      r_waddr <= (AWIDTH + 1)'(bin2gray(32'(w_wptr_nxt)));
      case (r_state)
        IDLE: begin
          if (w_last) begin
            r_rr_ptr <= w_rr_next;
          end else begin
            r_state     <= LOCKED;
            r_owner     <= NUM_REQ'(1) << w_sel;
            r_owner_idx <= w_sel;
          end
        end
        LOCKED: begin
          if (w_last) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= w_rr_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately left unreset; it is only read behind the pointers.
  always_ff @(posedge clk_pm_i) begin
    if (w_accept) begin
      r_mem[r_wptr[AWIDTH-1:0]] <= w_data;
    end
  end

  assign req_ready_o             = w_ready;
  assign full_o                  = w_full;
  assign owner_o                 = r_owner;
  assign noc_fifo_pm_out_waddr_o = r_waddr;
  assign noc_fifo_pm_out_data_o  = r_mem[w_rd_idx];

endmodule

// File: tb/tb_pm_noc_out_arbiter.sv
// Self-checking bench for pm_noc_out_arbiter: directed scenarios followed by
// a randomized run, all compared against an integer/queue reference model.
module tb_pm_noc_out_arbiter;

  localparam int NR = 3;
  localparam int PS = 8;
  localparam int AW = 2;
  localparam int SS = 2;
  localparam int GRAY_TAB [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] valid;
  logic [NR-1:0] last;
  logic [NR*PS-1:0] data;
  logic [NR-1:0] ready;
  logic [PS-1:0] dout;
  logic [AW:0]   raddr;
  logic [AW:0]   waddr;
  logic [NR-1:0] owner;
  logic          full;

  always #5 clk = ~clk;

  pm_noc_out_arbiter #(
    .NUM_REQ     (NR),
    .PACKET_SIZE (PS),
    .AWIDTH      (AW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_pm_i                (clk),
    .reset_pm_i              (rst),
    .req_valid_i             (valid),
    .req_last_i              (last),
    .req_data_i              (data),
    .req_ready_o             (ready),
    .noc_fifo_pm_out_data_o  (dout),
    .noc_fifo_pm_out_raddr_i (raddr),
    .noc_fifo_pm_out_waddr_o (waddr),
    .owner_o                 (owner),
    .full_o                  (full)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: packet owner (-1 = none), priority start, write count
  // mod 8, reader's binary pointer and the reader pointer as seen after the
  // synchroniser delay (front of a fixed-length queue).
  int         m_owner;
  int         m_prio;
  int         m_wcnt;
  int         m_rbin;
  int         m_seen_q [$];
  logic [7:0] m_mem [4];
  bit         m_written [4];
  logic [2:0] s_ready;
  int         dut_acc_cnt;

  assign raddr = 3'(GRAY_TAB[m_rbin]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int m_grant();
    if (m_owner >= 0) return m_owner;
    for (int i = 0; i < NR; i++) begin
      if (valid[(m_prio + i) % NR]) return (m_prio + i) % NR;
    end
    return -1;
  endfunction

  function automatic bit m_full();
    return ((m_wcnt - m_seen_q[0] + 8) % 8) == 4;
  endfunction

  // One clock: check combinational and registered outputs, then advance.
  task automatic step();
    int g;
    bit f;
    logic [2:0] er;
    #3;
    g  = m_grant();
    f  = m_full();
    er = (g >= 0 && !f) ? 3'(1 << g) : 3'b000;
    s_ready = ready;
    chk("ready", ready, er);
    chk("full", full, f);
    chk("owner", owner, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("waddr", waddr, GRAY_TAB[m_wcnt]);
    if (m_written[m_rbin % 4]) chk("data_o", dout, m_mem[m_rbin % 4]);
    if ((ready & valid) != 3'b000) dut_acc_cnt++;
    @(posedge clk);
    #1;
    if (g >= 0 && !f && valid[g]) begin
      m_mem[m_wcnt % 4]     = data[g*8 +: 8];
      m_written[m_wcnt % 4] = 1'b1;
      m_wcnt                = (m_wcnt + 1) % 8;
      if (m_owner < 0) begin
        if (last[g]) m_prio = (g + 1) % NR;
        else         m_owner = g;
      end else if (last[g]) begin
        m_owner = -1;
        m_prio  = (g + 1) % NR;
      end
    end
    m_seen_q.push_back(m_rbin);
    void'(m_seen_q.pop_front());
  endtask

  task automatic do_reset(input int n);
    rst    = 1'b1;
    m_rbin = 0;
    for (int i = 0; i < n; i++) begin
      #3;
      chk("ready_in_reset", ready, 0);
      @(posedge clk);
      #1;
    end
    m_owner     = -1;
    m_prio      = 0;
    m_wcnt      = 0;
    dut_acc_cnt = 0;
    m_seen_q.delete();
    for (int i = 0; i < SS; i++) m_seen_q.push_back(0);
    chk("reset_waddr", waddr, 0);
    chk("reset_owner", owner, 0);
    chk("reset_full", full, 0);
    rst = 1'b0;
  endtask

  task automatic rd_follow();
    m_rbin = m_wcnt;
  endtask

  localparam int RR_EXP [6]    = '{1, 2, 4, 1, 2, 4};
  localparam int BURST_EXP [5] = '{2, 2, 2, 4, 1};

  initial begin
    int n1;
    int budget;
    rst   = 1'b1;
    valid = '0;
    last  = '0;
    data  = '0;
    m_rbin = 0;
    for (int i = 0; i < 4; i++) m_written[i] = 1'b0;

    // Reset with every requester asserting valid.
    valid = 3'b111;
    last  = 3'b111;
    do_reset(3);

    // Single flit from requester 0.
    valid = 3'b001;
    last  = 3'b001;
    data  = 24'h0000A5;
    step();
    chk("single_ready", s_ready, 3'b001);
    valid = 3'b000;
    step();
    chk("single_waddr", waddr, 1);
    chk("single_data", dout, 8'hA5);

    // Round robin over single-flit packets.
    do_reset(1);
    valid = 3'b111;
    last  = 3'b111;
    for (int k = 0; k < 6; k++) begin
      data = 24'($urandom);
      rd_follow();
      step();
      chk("rr_order", s_ready, RR_EXP[k]);
    end

    // Move priority to requester 1, then a 3-flit burst from it.
    valid = 3'b001;
    last  = 3'b001;
    rd_follow();
    step();
    n1 = 0;
    for (int k = 0; k < 5; k++) begin
      valid = {1'b1, (n1 < 3), 1'b1};
      last  = {1'b1, (n1 == 2), 1'b1};
      data  = 24'($urandom);
      rd_follow();
      step();
      chk("burst_order", s_ready, BURST_EXP[k]);
      if (s_ready[1]) n1++;
      if (k == 0 || k == 1) chk("burst_owner_locked", owner, 3'b010);
      if (k == 2) chk("burst_owner_released", owner, 3'b000);
    end

    // Fill to full with the reader stalled, then release one slot.
    do_reset(1);
    valid = 3'b001;
    last  = 3'b001;
    for (int k = 0; k < 6; k++) begin
      data = 24'($urandom);
      step();
      chk("fill_ready", s_ready, (k < 4) ? 1 : 0);
    end
    chk("full_flag", full, 1);
    m_rbin = 1;
    for (int k = 0; k < 3; k++) begin
      data = 24'($urandom);
      step();
      chk("unblock_ready", s_ready, (k == SS) ? 1 : 0);
    end

    // Keep writing through two pointer wraps.
    budget = 200;
    while (dut_acc_cnt < 16 && budget > 0) begin
      data = 24'($urandom);
      rd_follow();
      step();
      if ((s_ready & valid) != 3'b000) chk("wrap_waddr_seq", waddr, GRAY_TAB[dut_acc_cnt % 8]);
      budget--;
    end
    chk("wrap_writes", dut_acc_cnt, 16);
    chk("wrap_waddr_final", waddr, 0);

    // Reset in the middle of a locked packet.
    do_reset(1);
    valid = 3'b100;
    last  = 3'b000;
    step();
    chk("mid_owner", owner, 3'b100);
    valid = 3'b111;
    last  = 3'b111;
    do_reset(1);
    step();
    chk("mid_first_grant", s_ready, 3'b001);

    // Randomized traffic with a randomly advancing reader.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      valid = 3'($urandom);
      last  = 3'($urandom);
      data  = 24'($urandom);
      if (m_wcnt != m_rbin && $urandom_range(0, 1) == 1) m_rbin = (m_rbin + 1) % 8;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pm_noc_out_arbiter.md
Name: pm_noc_out_arbiter

Overview:
Shares the PM domain's outbound NoC async-FIFO write side between several packet sources in the PM clock domain, such as the core tile, a debug/JTAG bridge and a UART bridge. It also holds the FIFO storage.
- Round-robin arbitration, locked for the length of a multi-flit packet.
- Tracks the FIFO write pointer and synchronises the remote read pointer.
- Publishes a gray-coded write pointer to the NoC clock domain.
- Sits between the PM requesters and the noc_fifo_pm_out_* boundary of the PM domain.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
PACKET_SIZE, NOC_ASYNC_FIFO_PACKET_SIZE, flit width in bits
AWIDTH, NOC_ASYNC_FIFO_AWIDTH, FIFO depth = 2^AWIDTH; pointers are AWIDTH+1 bits
SYNC_STAGES, 2, flop stages on the incoming read pointer (>=2)

Ports:
clk_pm_i  in  1  PM domain clock
reset_pm_i  in  1  synchronous active-high reset
req_valid_i  in  NUM_REQ  flit valid per requester
req_last_i  in  NUM_REQ  flit is last of packet, per requester
req_data_i  in  NUM_REQ*PACKET_SIZE  flits; requester k at [k*PACKET_SIZE +: PACKET_SIZE]
req_ready_o  out  NUM_REQ  flit accepted this cycle when valid&ready
noc_fifo_pm_out_data_o  out  PACKET_SIZE  storage word addressed by the remote read pointer
noc_fifo_pm_out_raddr_i  in  AWIDTH+1  gray read pointer from the NoC domain (asynchronous)
noc_fifo_pm_out_waddr_o  out  AWIDTH+1  gray write pointer, registered
owner_o  out  NUM_REQ  one-hot current packet owner, zero when idle (registered)
full_o  out  1  FIFO full as seen in the PM domain

Behaviour:
Interface: one clock; reset is synchronous and active-high.
- Clock and reset ports are clk_pm_i and reset_pm_i.

Reset values:
- wptr, noc_fifo_pm_out_waddr_o, all sync flops: 0.
- state = IDLE, owner_o = 0, rr_ptr = 0.
- req_ready_o is 0 during reset.
- The storage array is not reset.

Read pointer and full:
- noc_fifo_pm_out_raddr_i passes through SYNC_STAGES flops, then gray-to-binary, giving rptr_s.
- full_o is combinational: wptr[AWIDTH] != rptr_s[AWIDTH] and wptr[AWIDTH-1:0] == rptr_s[AWIDTH-1:0].
- Exactly 2^AWIDTH flits fit.

Data output:
- noc_fifo_pm_out_data_o = mem[gray2bin(raddr_i)[AWIDTH-1:0]], combinational.
- The reader keeps raddr stable across its sampling.

Arbitration, state IDLE:
- Candidate = first k with req_valid_i[k], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- req_ready_o[k] = !full_o for the candidate only; all others 0.

Arbitration, state LOCKED:
- Only the owner is eligible. req_ready_o[owner] = !full_o.
- Other requesters' valids are ignored.

Write (accept = valid & ready of the eligible requester):
- mem[wptr[AWIDTH-1:0]] <= data; wptr <= wptr+1 (wraps modulo 2^(AWIDTH+1)).
- noc_fifo_pm_out_waddr_o <= bin2gray(wptr+1).
- Storage and pointer update on the same edge, so the pointer becomes visible one cycle after accept.
- At most one flit per cycle.

Transitions:
- IDLE, accept with last=0: go to LOCKED, owner_o <= onehot(k).
- IDLE, accept with last=1: stay IDLE, rr_ptr <= k+1.
- LOCKED, accept with last=1: go to IDLE, owner_o <= 0, rr_ptr <= owner+1.
- No accept: state and rr_ptr unchanged.
  - A requester that was a candidate but was blocked by full keeps priority.

Boundary conditions:
- Full while LOCKED: the lock holds; the owner stalls.
- Owner dropping valid mid-packet: the lock holds indefinitely. This is a requester protocol error, not checked.
- Read pointer advancing while full: ready may rise SYNC_STAGES cycles after raddr changes, never earlier.
- Reset mid-packet: the lock is dropped and wptr returns to 0. The NoC-side reader must be reset in the same system reset.

Decomposition:
- Package pm_noc_fifo_pkg holds:
  - functions bin2gray(AWIDTH+1) and gray2bin(AWIDTH+1);
  - the arbiter state encoding (IDLE=0, LOCKED=1).
- PACKET_SIZE and AWIDTH come from the shared NoC parameter include.
- Sub-module pm_gray_ptr_sync (SYNC_STAGES flop chain plus gray-to-binary, outputs rptr_s). It is reused by the inbound FIFO reader.

Test Plan:
- Reset: assert reset_pm_i 3 cycles with valids high → req_ready_o=0, waddr_o=0, owner_o=0, full_o=0.
- Single flit: req0 valid, last=1, data=0xA5, raddr=0 → ready0=1 in the same cycle; waddr_o=1 (gray) next cycle; with raddr_i=0, data_o=0xA5.
- Round-robin: all three requesters hold single-flit packets continuously → accept order 0,1,2,0,1,2; no requester starved.
- Burst lock: req1 sends 3 flits (last on the 3rd) while req0 and req2 are valid → three consecutive req1 accepts, owner_o=3'b010 for flits 2–3, then req2 next, then req0.
- Full and wrap:
  - Stimulus: AWIDTH=2, raddr held 0, stream 6 flits.
  - Expect: exactly 4 accepted, then full_o=1 and ready=0.
  - Stimulus: step raddr gray 0→1.
  - Expect: ready rises exactly SYNC_STAGES cycles later.
  - Continue over 16 writes: waddr_o follows gray 0,1,3,2,6,7,5,4,0.
- Reset mid-packet: req2 LOCKED after 1 of 3 flits, assert reset → IDLE, owner_o=0, waddr_o=0; after release req0 is granted first.
